// File: rtl/service_desk_pkg.sv
// Shared constants, customer record and slot-select helper for the service desk.
package service_desk_pkg;

   localparam int unsigned NUM_CTR = 3;
   localparam int unsigned Q_DEPTH = 3;
   localparam int unsigned NUM_W   = 4;
   localparam int unsigned TIME_W  = 4;
   localparam int unsigned CNT_W   = 2;
   localparam int unsigned IDX_W   = 3;
   localparam int unsigned CUST_W  = NUM_W + TIME_W;
   localparam int unsigned QBUS_W  = Q_DEPTH * CUST_W;

   typedef struct packed {
      logic [NUM_W-1:0]  num;
      logic [TIME_W-1:0] tm;
   } cust_t;

   // Select queue slot k from the flat slot bus (slot 0 in the low byte).
   function automatic cust_t slot_pick(input logic [QBUS_W-1:0] bus,
                                       input logic [CNT_W-1:0]  k);
      cust_t c;
      case (k)
         2'd0:    c = cust_t'(bus[7:0]);
         2'd1:    c = cust_t'(bus[15:8]);
         2'd2:    c = cust_t'(bus[23:16]);
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/cust_fifo.sv
// 3-deep shift queue of customers: pops 0..3 from the head, one push at the tail.
import service_desk_pkg::*;

module cust_fifo (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [CNT_W-1:0]  pop_cnt,
   input  logic              push,
   input  cust_t             push_data,
   output logic [CNT_W-1:0]  count,
   output logic [QBUS_W-1:0] slots
);

   cust_t            q     [Q_DEPTH];
   cust_t            q_nxt [Q_DEPTH];
   logic [CNT_W-1:0] count_nxt;
   logic [CNT_W-1:0] remain;

   // Shift surviving entries toward slot 0, then append the push at the new tail.
   always_comb begin
      remain    = count - pop_cnt;
      count_nxt = remain;
      for (int k = 0; k < Q_DEPTH; k++) begin
         q_nxt[k] = '0;
         for (int s = 0; s < Q_DEPTH; s++) begin
            if ((IDX_W'(s) == IDX_W'(k) + IDX_W'(pop_cnt)) && (IDX_W'(s) < IDX_W'(count))) begin
               q_nxt[k] = q[s];
            end
         end
      end
      if (push && (remain < CNT_W'(Q_DEPTH))) begin
         for (int k = 0; k < Q_DEPTH; k++) begin
            if (CNT_W'(k) == remain) begin
               q_nxt[k] = push_data;
            end
         end
         count_nxt = remain + CNT_W'(1);
      end
   end

   // Queue storage and occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
         for (int k = 0; k < Q_DEPTH; k++) begin
            q[k] <= '0;
         end
      end else begin
         count <= count_nxt;
         for (int k = 0; k < Q_DEPTH; k++) begin
            q[k] <= q_nxt[k];
         end
      end
   end

   for (genvar k = 0; k < Q_DEPTH; k++) begin : g_slot
      assign slots[k*CUST_W +: CUST_W] = q[k];
   end

endmodule

// File: rtl/service_desk_top.sv
// Three-counter service desk with a 3-entry waiting queue.
// Define SERVICE_DESK_QDBG_EN to expose the queue contents on qdbg.
import service_desk_pkg::*;

module service_desk_top (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic [3:0]  in_num,
   input  logic [3:0]  in_time,
   output logic [3:0]  num1,
   output logic [3:0]  clk1,
   output logic [3:0]  num2,
   output logic [3:0]  clk2,
   output logic [3:0]  num3,
   output logic [3:0]  clk3,
   output logic [23:0] qdbg
);

   logic              rst_meta_n;
   logic              rst_sync_n;
   cust_t             ctr_q [NUM_CTR];
   cust_t             ctr_d [NUM_CTR];
   logic [CNT_W-1:0]  q_count;
   logic [QBUS_W-1:0] q_slots;
   logic [CNT_W-1:0]  pop_cnt;
   logic              push;
   cust_t             arrival;
   logic              arrival_ok;
   logic              placed;
   logic [NUM_CTR-1:0] taken;

   // Reset synchronizer: asynchronous assertion, release aligned to clk.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rst_meta_n <= 1'b0;
         rst_sync_n <= 1'b0;
      end else begin
         rst_meta_n <= 1'b1;
         rst_sync_n <= rst_meta_n;
      end
   end

   // Arbitration: service countdown, queue pops into idle counters, then the arrival.
   always_comb begin
      pop_cnt    = '0;
      push       = 1'b0;
      placed     = 1'b0;
      taken      = '0;
      arrival    = '{num: in_num, tm: in_time};
      arrival_ok = in_valid && (in_time != '0);
      for (int i = 0; i < NUM_CTR; i++) begin
         ctr_d[i] = ctr_q[i];
         if (ctr_q[i].tm != '0) begin
            ctr_d[i].tm = ctr_q[i].tm - TIME_W'(1);
            if (ctr_q[i].tm == TIME_W'(1)) begin
               ctr_d[i].num = '0;
            end
         end
      end
      for (int i = 0; i < NUM_CTR; i++) begin
         if ((ctr_q[i].tm == '0) && (pop_cnt < q_count)) begin
            ctr_d[i] = slot_pick(q_slots, pop_cnt);
            taken[i] = 1'b1;
            pop_cnt  = pop_cnt + CNT_W'(1);
         end
      end
      if (arrival_ok && (q_count == '0)) begin
         for (int i = 0; i < NUM_CTR; i++) begin
            if ((ctr_q[i].tm == '0) && !taken[i] && !placed) begin
               ctr_d[i] = arrival;
               placed   = 1'b1;
            end
         end
      end
      if (arrival_ok && !placed && ((q_count - pop_cnt) < CNT_W'(Q_DEPTH))) begin
         push = 1'b1;
      end
   end

   // Counter registers.
   always_ff @(posedge clk or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
         for (int i = 0; i < NUM_CTR; i++) begin
            ctr_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_CTR; i++) begin
            ctr_q[i] <= ctr_d[i];
         end
      end
   end

   cust_fifo u_fifo (
      .clk       (clk),
      .rst_n     (rst_sync_n),
      .pop_cnt   (pop_cnt),
      .push      (push),
      .push_data (arrival),
      .count     (q_count),
      .slots     (q_slots)
   );

   assign num1 = ctr_q[0].num;
   assign clk1 = ctr_q[0].tm;
   assign num2 = ctr_q[1].num;
   assign clk2 = ctr_q[1].tm;
   assign num3 = ctr_q[2].num;
   assign clk3 = ctr_q[2].tm;

`ifdef SERVICE_DESK_QDBG_EN
   assign qdbg = q_slots;
`else
   assign qdbg = 24'h0;
`endif

endmodule

// File: tb/tb_service_desk_top.sv
// Directed table-driven bench for service_desk_top.
module tb_service_desk_top;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [3:0]  in_num;
   logic [3:0]  in_time;
   logic [3:0]  num1, clk1, num2, clk2, num3, clk3;
   logic [23:0] qdbg;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      logic        rst;
      logic        v;
      logic [3:0]  n;
      logic [3:0]  t;
      logic [23:0] ctr;   // {num1,clk1,num2,clk2,num3,clk3}
      logic [23:0] q;
   } vec_t;

   vec_t tbl[$];

   service_desk_top dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_num   (in_num),
      .in_time  (in_time),
      .num1     (num1),
      .clk1     (clk1),
      .num2     (num2),
      .clk2     (clk2),
      .num3     (num3),
      .clk3     (clk3),
      .qdbg     (qdbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [23:0] qexp(input logic [23:0] q);
`ifdef SERVICE_DESK_QDBG_EN
      return q;
`else
      return 24'h0 & q;
`endif
   endfunction

   function automatic vec_t mk(input logic rst, input logic v, input logic [3:0] n,
                               input logic [3:0] t, input logic [23:0] ctr, input logic [23:0] q);
      vec_t x;
      x.rst = rst; x.v = v; x.n = n; x.t = t; x.ctr = ctr; x.q = q;
      return x;
   endfunction

   task automatic check(input string name, input logic [23:0] ectr, input logic [23:0] eq);
      logic [47:0] got;
      logic [47:0] exp;
      got = {num1, clk1, num2, clk2, num3, clk3, qdbg};
      exp = {ectr, qexp(eq)};
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic step(input logic v, input logic [3:0] n, input logic [3:0] t);
      @(negedge clk);
      in_valid = v;
      in_num   = n;
      in_time  = t;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n    = 1'b0;
      in_valid = 1'b1;
      in_num   = 4'd5;
      in_time  = 4'd5;
      repeat (2) @(posedge clk);
      #1;
      check("rst_hold", 24'h0, 24'h0);
      @(negedge clk);
      rst_n    = 1'b1;
      in_valid = 1'b0;
      in_num   = 4'd0;
      in_time  = 4'd0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("rst_release%0d", k), 24'h0, 24'h0);
      end
   endtask

   task automatic add_fill(input logic rst);
      tbl.push_back(mk(rst,  1'b1, 4'd1, 4'd9, 24'h190000, 24'h000000));
      tbl.push_back(mk(1'b0, 1'b1, 4'd2, 4'd9, 24'h182900, 24'h000000));
      tbl.push_back(mk(1'b0, 1'b1, 4'd3, 4'd9, 24'h172839, 24'h000000));
      tbl.push_back(mk(1'b0, 1'b1, 4'd4, 4'd9, 24'h162738, 24'h000049));
      tbl.push_back(mk(1'b0, 1'b1, 4'd5, 4'd9, 24'h152637, 24'h005949));
      tbl.push_back(mk(1'b0, 1'b1, 4'd6, 4'd9, 24'h142536, 24'h695949));
      tbl.push_back(mk(1'b0, 1'b1, 4'd7, 4'd9, 24'h132435, 24'h695949));
      tbl.push_back(mk(1'b0, 1'b0, 4'd0, 4'd0, 24'h122334, 24'h695949));
      tbl.push_back(mk(1'b0, 1'b0, 4'd0, 4'd0, 24'h112233, 24'h695949));
      tbl.push_back(mk(1'b0, 1'b0, 4'd0, 4'd0, 24'h002132, 24'h695949));
   endtask

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_num   = 4'd0;
      in_time  = 4'd0;

      // Single customer (1,3).
      tbl.push_back(mk(1'b1, 1'b1, 4'd1, 4'd3, 24'h130000, 24'h000000));
      tbl.push_back(mk(1'b0, 1'b0, 4'd0, 4'd0, 24'h120000, 24'h000000));
      tbl.push_back(mk(1'b0, 1'b0, 4'd0, 4'd0, 24'h110000, 24'h000000));
      tbl.push_back(mk(1'b0, 1'b0, 4'd0, 4'd0, 24'h000000, 24'h000000));
      // Back-to-back fill, drop of 7, then same-edge pop with arrival (8,2).
      add_fill(1'b0);
      tbl.push_back(mk(1'b0, 1'b1, 4'd8, 4'd2, 24'h490031, 24'h826959));
      tbl.push_back(mk(1'b0, 1'b0, 4'd0, 4'd0, 24'h485900, 24'h008269));
      tbl.push_back(mk(1'b0, 1'b0, 4'd0, 4'd0, 24'h475869, 24'h000082));
      tbl.push_back(mk(1'b0, 1'b0, 4'd0, 4'd0, 24'h465768, 24'h000082));
      // Same fill after a reset, head pop with no arrival.
      add_fill(1'b1);
      tbl.push_back(mk(1'b0, 1'b0, 4'd0, 4'd0, 24'h490031, 24'h006959));
      tbl.push_back(mk(1'b0, 1'b0, 4'd0, 4'd0, 24'h485900, 24'h000069));

      for (int i = 0; i < tbl.size(); i++) begin
         if (tbl[i].rst) do_reset();
         step(tbl[i].v, tbl[i].n, tbl[i].t);
         check($sformatf("vec%0d", i), tbl[i].ctr, tbl[i].q);
      end

      // Zero service time with all counters idle is ignored.
      do_reset();
      step(1'b1, 4'd9, 4'd0);
      check("zero_time", 24'h000000, 24'h000000);
      step(1'b0, 4'd0, 4'd0);
      check("zero_time_after", 24'h000000, 24'h000000);

      // Asynchronous reset mid-service clears counters and queue at once.
      step(1'b1, 4'd1, 4'd5);
      check("load_a", 24'h150000, 24'h000000);
      step(1'b1, 4'd2, 4'd5);
      check("load_b", 24'h142500, 24'h000000);
      step(1'b1, 4'd3, 4'd5);
      check("load_c", 24'h132435, 24'h000000);
      step(1'b1, 4'd4, 4'd5);
      check("load_q", 24'h122334, 24'h000045);
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst", 24'h000000, 24'h000000);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("post_rst", 24'h000000, 24'h000000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
